// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 shared constants: icodes, stat codes, register IDs, CC bits
package y86_pkg;

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  // Flag vector layout is {OF,SF,ZF}
  localparam int CC_OF = 2;
  localparam int CC_SF = 1;
  localparam int CC_ZF = 0;
  localparam logic [2:0] CC_RESET = 3'b001;

  typedef struct packed {
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    stat_e       stat;
  } m_reg_t;

  function automatic m_reg_t m_reg_bubble();
    m_reg_t b;
    b.icode = I_NOP;
    b.cnd   = 1'b0;
    b.val_e = '0;
    b.val_a = '0;
    b.dst_e = RNONE;
    b.dst_m = RNONE;
    b.stat  = STAT_AOK;
    return b;
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// rtl/memory_stage_if.sv - E-to-M inputs, pipeline control and M-stage outputs
interface memory_stage_if;
  logic [3:0]  e_icode;
  logic        e_Cnd;
  logic [63:0] e_valE;
  logic [63:0] e_valA;
  logic [3:0]  e_dstE;
  logic [3:0]  e_dstM;
  logic [2:0]  e_stat;
  logic        e_set_cc;
  logic [2:0]  e_new_cc;
  logic        M_stall;
  logic        M_bubble;
  logic [2:0]  W_stat;

  logic [2:0]  cc;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic [63:0] m_valM;
  logic [2:0]  m_stat;
  logic        dmem_error;

  modport master (
    output e_icode, e_Cnd, e_valE, e_valA, e_dstE, e_dstM, e_stat,
           e_set_cc, e_new_cc, M_stall, M_bubble, W_stat,
    input  cc, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM,
           m_valM, m_stat, dmem_error
  );

  modport slave (
    input  e_icode, e_Cnd, e_valE, e_valA, e_dstE, e_dstM, e_stat,
           e_set_cc, e_new_cc, M_stall, M_bubble, W_stat,
    output cc, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM,
           m_valM, m_stat, dmem_error
  );
endinterface

// File: rtl/data_memory.sv
// rtl/data_memory.sv - byte-addressed data memory, 8-byte little-endian access, bounds check
module data_memory #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 64
) (
  input  logic              clock,
  input  logic [ADDR_W-1:0] addr,
  input  logic              read,
  input  logic              write,
  input  logic              write_ok,
  input  logic [63:0]       wdata,
  output logic [63:0]       rdata,
  output logic              error
);
  localparam int IDX_W = $clog2(MEM_BYTES);
  localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'(MEM_BYTES - 8);

  logic [7:0]       mem [MEM_BYTES];
  logic [IDX_W-1:0] base;

  assign base  = addr[IDX_W-1:0];
  // Full-width unsigned compare: high address bits can never alias into range
  assign error = (read || write) && (addr > LAST_BASE);

  always_comb begin
    rdata = '0;
    if (read && !error) begin
      for (int i = 0; i < 8; i++) begin
        rdata[8*i +: 8] = mem[base + IDX_W'(i)];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (write && write_ok && !error) begin
      for (int i = 0; i < 8; i++) begin
        mem[base + IDX_W'(i)] <= wdata[8*i +: 8];
      end
    end
  end
endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - Y86-64 M stage: E-to-M register, condition codes, data memory access
module memory_stage
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 64
) (
  input logic           clock,
  input logic           reset,
  memory_stage_if.slave bus
);
  m_reg_t            m_q;
  m_reg_t            m_load;
  logic [2:0]        cc_q;
  logic              mem_read;
  logic              mem_write;
  logic              mem_error;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_rdata;
  logic [2:0]        m_stat;
  logic              w_ok;

  always_comb begin
    m_load.icode = bus.e_icode;
    m_load.cnd   = bus.e_Cnd;
    m_load.val_e = bus.e_valE;
    m_load.val_a = bus.e_valA;
    // A conditional move that is not taken must not write its destination
    m_load.dst_e = (bus.e_icode == I_CMOVXX && !bus.e_Cnd) ? RNONE : bus.e_dstE;
    m_load.dst_m = bus.e_dstM;
    m_load.stat  = stat_e'(bus.e_stat);
  end

  always_ff @(posedge clock) begin
    if (reset || bus.M_bubble) begin
      m_q <= m_reg_bubble();
    end else if (!bus.M_stall) begin
      m_q <= m_load;
    end
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = m_q.val_e[ADDR_W-1:0];
    case (m_q.icode)
      I_RMMOVQ, I_PUSHQ, I_CALL: mem_write = 1'b1;
      I_MRMOVQ:                  mem_read  = 1'b1;
      I_POPQ, I_RET: begin
        mem_read = 1'b1;
        mem_addr = m_q.val_a[ADDR_W-1:0];
      end
      default: ;
    endcase
  end

  assign w_ok   = !reset && (bus.W_stat == STAT_AOK);
  assign m_stat = mem_error ? STAT_ADR : m_q.stat;

  data_memory #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_dmem (
    .clock    (clock),
    .addr     (mem_addr),
    .read     (mem_read),
    .write    (mem_write),
    .write_ok (w_ok),
    .wdata    (m_q.val_a),
    .rdata    (mem_rdata),
    .error    (mem_error)
  );

  // Flags are frozen once an exception sits in M or W
  always_ff @(posedge clock) begin
    if (reset) begin
      cc_q <= CC_RESET;
    end else if (bus.e_set_cc && bus.e_icode == I_OPQ &&
                 m_stat == STAT_AOK && bus.W_stat == STAT_AOK) begin
      cc_q <= bus.e_new_cc;
    end
  end

  assign bus.cc         = cc_q;
  assign bus.M_icode    = m_q.icode;
  assign bus.M_Cnd      = m_q.cnd;
  assign bus.M_valE     = m_q.val_e;
  assign bus.M_valA     = m_q.val_a;
  assign bus.M_dstE     = m_q.dst_e;
  assign bus.M_dstM     = m_q.dst_m;
  assign bus.m_valM     = mem_rdata;
  assign bus.m_stat     = m_stat;
  assign bus.dmem_error = mem_error;
endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - vector table with scoreboard plus stall/bubble/reset sequences for memory_stage
module tb_memory_stage;
  localparam int MB = 1024;

  typedef struct {
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [2:0]  stat;
    logic        set_cc;
    logic [2:0]  new_cc;
    logic [2:0]  w_stat;
    logic [3:0]  x_dst_e;
    logic [63:0] x_val_m;
    logic [2:0]  x_stat;
    logic        x_err;
    logic [2:0]  x_cc;
  } vec_t;

  typedef struct {
    int          row;
    logic [3:0]  icode;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [63:0] val_m;
    logic [2:0]  stat;
    logic        err;
    logic [2:0]  cc;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  memory_stage_if bus();

  memory_stage #(.MEM_BYTES(MB), .ADDR_W(64)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int   errors = 0;
  int   checks = 0;
  vec_t vt[$];
  exp_t sb[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic vec_t mk(logic [3:0] icode, logic cnd, logic [63:0] val_e, logic [63:0] val_a,
                              logic [3:0] dst_e, logic [3:0] dst_m, logic [2:0] stat, logic set_cc,
                              logic [2:0] new_cc, logic [2:0] w_stat, logic [3:0] x_dst_e,
                              logic [63:0] x_val_m, logic [2:0] x_stat, logic x_err, logic [2:0] x_cc);
    vec_t v;
    v.icode = icode; v.cnd = cnd; v.val_e = val_e; v.val_a = val_a;
    v.dst_e = dst_e; v.dst_m = dst_m; v.stat = stat; v.set_cc = set_cc;
    v.new_cc = new_cc; v.w_stat = w_stat; v.x_dst_e = x_dst_e; v.x_val_m = x_val_m;
    v.x_stat = x_stat; v.x_err = x_err; v.x_cc = x_cc;
    return v;
  endfunction

  task automatic drive(vec_t v);
    bus.e_icode  = v.icode;
    bus.e_Cnd    = v.cnd;
    bus.e_valE   = v.val_e;
    bus.e_valA   = v.val_a;
    bus.e_dstE   = v.dst_e;
    bus.e_dstM   = v.dst_m;
    bus.e_stat   = v.stat;
    bus.e_set_cc = v.set_cc;
    bus.e_new_cc = v.new_cc;
    bus.W_stat   = v.w_stat;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    exp_t e;
    vec_t idle;
    idle = mk(4'h1, 0, 0, 0, 4'hF, 4'hF, 3'd1, 0, 3'b000, 3'd1, 4'hF, 0, 3'd1, 0, 3'b001);
    drive(idle);
    bus.M_stall  = 1'b0;
    bus.M_bubble = 1'b0;
    reset = 1'b1;
    tick();
    tick();

    chk("reset M_icode", 64'(bus.M_icode), 64'h1);
    chk("reset M_valE", bus.M_valE, 64'h0);
    chk("reset M_valA", bus.M_valA, 64'h0);
    chk("reset M_dstE", 64'(bus.M_dstE), 64'hF);
    chk("reset M_dstM", 64'(bus.M_dstM), 64'hF);
    chk("reset M_Cnd", 64'(bus.M_Cnd), 64'h0);
    chk("reset cc", 64'(bus.cc), 64'h1);
    chk("reset m_stat", 64'(bus.m_stat), 64'h1);
    reset = 1'b0;

    // icode cnd valE valA dstE dstM stat set new W | xdstE xvalM xstat xerr xcc
    vt.push_back(mk(4'h4, 0, 64'h8,  64'h0F0E0D0C0B0A0908, 4'hF, 4'hF, 1, 0, 3'b000, 1, 4'hF, 0, 1, 0, 3'b001));
    vt.push_back(mk(4'h4, 0, 64'h10, 64'h1122334455667788, 4'hF, 4'hF, 1, 0, 3'b000, 1, 4'hF, 0, 1, 0, 3'b001));
    vt.push_back(mk(4'h5, 0, 64'h10, 0, 4'hF, 4'h2, 1, 0, 3'b000, 1, 4'hF, 64'h1122334455667788, 1, 0, 3'b001));
    vt.push_back(mk(4'h5, 0, 64'h0F, 0, 4'hF, 4'h3, 1, 0, 3'b000, 1, 4'hF, 64'h223344556677880F, 1, 0, 3'b001));
    vt.push_back(mk(4'h5, 0, 64'(MB-7), 0, 4'hF, 4'h3, 1, 0, 3'b000, 1, 4'hF, 0, 3, 1, 3'b001));
    // ADR still in M at this edge, so the OPQ flag update is suppressed
    vt.push_back(mk(4'h6, 0, 64'h5, 0, 4'h3, 4'hF, 1, 1, 3'b010, 1, 4'h3, 0, 1, 0, 3'b001));
    vt.push_back(mk(4'h6, 0, 64'h6, 0, 4'h3, 4'hF, 1, 1, 3'b010, 1, 4'h3, 0, 1, 0, 3'b010));
    vt.push_back(mk(4'h6, 0, 64'h7, 0, 4'h3, 4'hF, 1, 1, 3'b100, 3, 4'h3, 0, 1, 0, 3'b010));
    vt.push_back(mk(4'h4, 0, 64'(MB-8), 64'hDEADBEEFCAFEF00D, 4'hF, 4'hF, 1, 0, 3'b000, 1, 4'hF, 0, 1, 0, 3'b010));
    vt.push_back(mk(4'h5, 0, 64'(MB-8), 0, 4'hF, 4'h1, 1, 0, 3'b000, 1, 4'hF, 64'hDEADBEEFCAFEF00D, 1, 0, 3'b010));
    vt.push_back(mk(4'h4, 0, 64'hFFFFFFFFFFFFFFF8, 64'hAAAAAAAAAAAAAAAA, 4'hF, 4'hF, 1, 0, 3'b000, 1, 4'hF, 0, 3, 1, 3'b010));
    vt.push_back(mk(4'h5, 0, 64'h10, 0, 4'hF, 4'h2, 1, 0, 3'b000, 1, 4'hF, 64'h1122334455667788, 1, 0, 3'b010));
    vt.push_back(mk(4'h5, 0, 64'(MB-8), 0, 4'hF, 4'h2, 1, 0, 3'b000, 1, 4'hF, 64'hDEADBEEFCAFEF00D, 1, 0, 3'b010));
    vt.push_back(mk(4'h2, 0, 64'h42, 64'h42, 4'h3, 4'hF, 1, 0, 3'b000, 1, 4'hF, 0, 1, 0, 3'b010));
    vt.push_back(mk(4'h2, 1, 64'h42, 64'h42, 4'h3, 4'hF, 1, 0, 3'b000, 1, 4'h3, 0, 1, 0, 3'b010));
    vt.push_back(mk(4'hB, 0, 64'h18, 64'h10, 4'h4, 4'h0, 1, 0, 3'b000, 1, 4'h4, 64'h1122334455667788, 1, 0, 3'b010));
    vt.push_back(mk(4'hA, 0, 64'h20, 64'h5555, 4'h4, 4'hF, 1, 0, 3'b000, 1, 4'h4, 0, 1, 0, 3'b010));
    vt.push_back(mk(4'h9, 0, 64'h28, 64'h20, 4'h4, 4'hF, 1, 0, 3'b000, 1, 4'h4, 64'h5555, 1, 0, 3'b010));
    vt.push_back(mk(4'hA, 0, 64'h10, 64'h77, 4'h4, 4'hF, 1, 0, 3'b000, 1, 4'h4, 0, 1, 0, 3'b010));
    // W holds HLT while the PUSHQ above commits: store must be dropped
    vt.push_back(mk(4'h5, 0, 64'h10, 0, 4'hF, 4'h2, 1, 0, 3'b000, 2, 4'hF, 64'h1122334455667788, 1, 0, 3'b010));
    vt.push_back(mk(4'h1, 0, 0, 0, 4'hF, 4'hF, 4, 0, 3'b000, 1, 4'hF, 0, 4, 0, 3'b010));
    vt.push_back(mk(4'h6, 0, 0, 0, 4'h3, 4'hF, 1, 1, 3'b001, 1, 4'h3, 0, 1, 0, 3'b010));
    vt.push_back(mk(4'h6, 0, 0, 0, 4'h3, 4'hF, 1, 1, 3'b001, 1, 4'h3, 0, 1, 0, 3'b001));

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i]);
      e.row = i; e.icode = vt[i].icode; e.dst_e = vt[i].x_dst_e; e.dst_m = vt[i].dst_m;
      e.val_m = vt[i].x_val_m; e.stat = vt[i].x_stat; e.err = vt[i].x_err; e.cc = vt[i].x_cc;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      chk($sformatf("row%0d M_icode", e.row), 64'(bus.M_icode), 64'(e.icode));
      chk($sformatf("row%0d M_dstE", e.row), 64'(bus.M_dstE), 64'(e.dst_e));
      chk($sformatf("row%0d M_dstM", e.row), 64'(bus.M_dstM), 64'(e.dst_m));
      chk($sformatf("row%0d m_valM", e.row), bus.m_valM, e.val_m);
      chk($sformatf("row%0d m_stat", e.row), 64'(bus.m_stat), 64'(e.stat));
      chk($sformatf("row%0d dmem_error", e.row), 64'(bus.dmem_error), 64'(e.err));
      chk($sformatf("row%0d cc", e.row), 64'(bus.cc), 64'(e.cc));
    end

    drive(mk(4'h6, 0, 64'h99, 64'h1, 4'h5, 4'hF, 1, 0, 3'b000, 1, 0, 0, 0, 0, 0));
    tick();
    chk("stall pre M_valE", bus.M_valE, 64'h99);
    drive(mk(4'h6, 0, 64'h123, 64'h2, 4'h7, 4'h2, 1, 1, 3'b100, 1, 0, 0, 0, 0, 0));
    bus.M_stall = 1'b1;
    tick();
    chk("stall1 M_valE", bus.M_valE, 64'h99);
    chk("stall1 M_dstE", 64'(bus.M_dstE), 64'h5);
    chk("stall1 M_valA", bus.M_valA, 64'h1);
    chk("stall1 cc", 64'(bus.cc), 64'b100);
    bus.e_new_cc = 3'b010;
    tick();
    chk("stall2 M_valE", bus.M_valE, 64'h99);
    chk("stall2 M_dstM", 64'(bus.M_dstM), 64'hF);
    chk("stall2 cc", 64'(bus.cc), 64'b010);

    bus.e_set_cc = 1'b0;
    bus.M_bubble = 1'b1;
    tick();
    chk("bubble M_icode", 64'(bus.M_icode), 64'h1);
    chk("bubble M_dstE", 64'(bus.M_dstE), 64'hF);
    chk("bubble M_dstM", 64'(bus.M_dstM), 64'hF);
    chk("bubble M_valE", bus.M_valE, 64'h0);
    bus.M_stall  = 1'b0;
    bus.M_bubble = 1'b0;

    drive(mk(4'h4, 0, 64'h10, 64'hFFFFFFFFFFFFFFFF, 4'hF, 4'hF, 1, 1, 3'b100, 1, 0, 0, 0, 0, 0));
    tick();
    chk("rstw pre M_icode", 64'(bus.M_icode), 64'h4);
    reset = 1'b1;
    tick();
    chk("rstw M_icode", 64'(bus.M_icode), 64'h1);
    chk("rstw M_valE", bus.M_valE, 64'h0);
    chk("rstw M_valA", bus.M_valA, 64'h0);
    chk("rstw M_dstE", 64'(bus.M_dstE), 64'hF);
    chk("rstw cc", 64'(bus.cc), 64'b001);
    chk("rstw m_stat", 64'(bus.m_stat), 64'h1);
    chk("rstw dmem_error", 64'(bus.dmem_error), 64'h0);
    reset = 1'b0;
    drive(mk(4'h5, 0, 64'h10, 0, 4'hF, 4'h2, 1, 0, 3'b000, 1, 0, 0, 0, 0, 0));
    tick();
    chk("rstw mem intact", bus.m_valM, 64'h1122334455667788);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/memory_stage.md
# memory_stage

Y86-64 pipeline block directly downstream of `execute`. It holds the E→M pipeline register, the architectural condition-code register that feeds `cc` back into `execute`, and byte-addressed data memory with address-error detection. It produces the M-stage values consumed by write-back and the forwarding logic.

## Interface
Parameters:
- `MEM_BYTES`, 1024: data memory size in bytes.
- `ADDR_W`, 64: address width. Full 64-bit address is range-checked.

Ports:
- `clock` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `e_icode` in 4: instruction code from execute.
- `e_Cnd` in 1: condition flag from execute.
- `e_valE` in 64: ALU result from execute.
- `e_valA` in 64: valA passed through execute.
- `e_dstE` in 4: destination register for valE.
- `e_dstM` in 4: destination register for valM.
- `e_stat` in 3: status from execute.
- `e_set_cc` in 1: execute requests a CC update.
- `e_new_cc` in 3: new flags from execute, bit order {OF,SF,ZF}.
- `M_stall` in 1: hold the M register.
- `M_bubble` in 1: load a NOP into the M register.
- `W_stat` in 3: status of the instruction in write-back.
- `cc` out 3: architectural flags to execute, {OF,SF,ZF}.
- `M_icode` out 4: registered M-stage instruction code.
- `M_Cnd` out 1: registered condition flag.
- `M_valE` out 64: registered ALU result.
- `M_valA` out 64: registered valA.
- `M_dstE` out 4: registered valE destination.
- `M_dstM` out 4: registered valM destination.
- `m_valM` out 64: combinational memory read data.
- `m_stat` out 3: combinational M-stage status.
- `dmem_error` out 1: combinational memory address error.

## Operation
- **Stat codes:** AOK=1, HLT=2, ADR=3, INS=4.
- **Register ID:** RNONE=4'hF.
- **Icodes used:** NOP=1, CMOVXX=2, RMMOVQ=4, MRMOVQ=5, OPQ=6, CALL=8, RET=9, PUSHQ=A, POPQ=B.
- **M register load (edge, not stalled, no bubble):** latch all `e_*` fields, with one exception. If `e_icode`=CMOVXX and `e_Cnd`=0, `M_dstE` loads RNONE.
- **Bubble value (also the reset value):**
  - `M_icode`=NOP, `M_stat`=AOK, `M_Cnd`=0.
  - `M_valE`=`M_valA`=0.
  - `M_dstE`=`M_dstM`=RNONE.
- **Register priority:** reset > bubble > stall > load.
- **Memory address:**
  - `M_valE` for RMMOVQ, PUSHQ, CALL, MRMOVQ.
  - `M_valA` for POPQ, RET.
- **Memory read:** asserted for MRMOVQ, POPQ, RET. `m_valM` is the 8 bytes at the address, little-endian. Otherwise `m_valM`=0.
- **Memory write:** asserted for RMMOVQ, PUSHQ, CALL. Data is `M_valA`, little-endian.
- **`dmem_error`:** (read or write) and address > MEM_BYTES−8, using unsigned 64-bit compare with no wrap-around.
- **`m_stat`:** ADR if `dmem_error`, else `M_stat`.
- **Write commit:** on the edge only when write && !`dmem_error` && !`reset` && `W_stat`∈{AOK}. `M_stall` does not gate the write.
- **CC update (edge):** `cc` loads `e_new_cc` when all of the following hold:
  - `e_set_cc`=1 and `e_icode`=OPQ;
  - `m_stat`∈{AOK};
  - `W_stat`∈{AOK}.
- **CC reset:** `cc`=3'b001 (ZF=1).
- **Memory contents:** not cleared by reset.

## Timing
- M register: 1-cycle latency from `e_*` to `M_*`.
- `m_valM`, `m_stat`, `dmem_error`: same cycle as `M_*`, combinational.
- A write at edge N is visible to a read of the same address in cycle N+1. A read and write never coincide, since only one instruction occupies M.
- `cc` is visible to execute one cycle after the OPQ's E cycle.
- Reset asserted mid-operation: on that edge, `M_*` take bubble values, `cc`=001, and no memory write occurs.
- `M_stall` held for k cycles: `M_*` stable for k cycles, and `cc` still updates per its own rule.

## Structure
- Shared package `y86_pkg`: icode constants, stat codes, RNONE, CC bit indices.
- Sub-module `data_memory`, holding:
  - `MEM_BYTES` byte array;
  - combinational 8-byte little-endian read;
  - synchronous 8-byte write with enable;
  - bounds check driving `dmem_error`.
- Top level holds the M register, CC register, address/control decode and `m_stat`.

## Test plan
- **Store then load:** RMMOVQ `valE`=0x10, `valA`=0x1122334455667788, then MRMOVQ `valE`=0x10 → `m_valM`=0x1122334455667788. Byte 0x10 reads 0x88 through an unaligned load at 0x0F with byte 0x0F known.
- **Bounds:** MRMOVQ `valE`=MEM_BYTES−7 → `dmem_error`=1, `m_stat`=3. RMMOVQ at 0xFFFFFFFFFFFFFFF8 → no write, `m_stat`=3. MEM_BYTES−8 → OK.
- **CMOV not taken:** CMOVXX with `e_Cnd`=0, `e_dstE`=3 → `M_dstE`=F next cycle. With `e_Cnd`=1 → `M_dstE`=3.
- **CC gating:**
  - OPQ, `e_new_cc`=3'b010, all stats AOK → `cc`=010.
  - Same with `W_stat`=ADR → `cc` unchanged.
  - After reset → `cc`=001.
- **Stall/bubble:**
  - Assert `M_stall` 2 cycles → `M_*` frozen.
  - `M_stall`+`M_bubble` together → `M_icode`=1, `M_dstE`=`M_dstM`=F.
- **Reset during write:** RMMOVQ in M with `reset`=1 → memory unchanged, `M_icode`=1, all outputs at reset values.
